// File: rtl/seq_divider8.sv
// seq_divider8: iterative radix-2 restoring unsigned divider.
// One quotient bit per clock, MSB first, under a start/busy/done handshake.
// A zero divisor completes immediately with quotient all-ones,
// remainder = dividend and div_by_zero set.
module seq_divider8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    // Counter wide enough to index WIDTH iterations (0 .. WIDTH-1).
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Working registers: partial remainder keeps a spare top bit so the
    // trial subtraction's sign is never lost.
    logic [WIDTH:0]   r_pr;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_count;

    // Result registers, updated only at a completion edge.
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic             w_accept;
    logic             w_zero;
    logic             w_last;
    logic [WIDTH:0]   w_pr_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH:0]   w_pr_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    // start is honoured in IDLE and FIN; while RUN it is ignored.
    assign w_accept = start && (r_state != S_RUN);
    assign w_zero   = (divisor == '0);
    assign w_last   = (r_count == LAST_ITER);

    // One restoring iteration: shift {PR,Q} left, trial-subtract the divisor,
    // keep the difference only when it is non-negative.
    always_comb begin
        w_pr_shift = (r_pr << 1) | {{WIDTH{1'b0}}, r_q[WIDTH-1]};
        w_trial    = w_pr_shift - {1'b0, r_dvs};
        w_qbit     = ~w_trial[WIDTH];
        w_pr_nxt   = w_qbit ? w_trial : w_pr_shift;
        w_q_nxt    = {r_q[WIDTH-2:0], w_qbit};
    end

    // State register.
    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept from IDLE/FIN, iterate in RUN, FIN lasts one cycle.
    // NOTE: the default assignment first guarantees no latch is inferred
    // for paths that do not assign the next state explicitly.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_FIN: begin
                if (start) begin
                    w_state_nxt = w_zero ? S_FIN : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_FIN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pr    <= '0;
            r_q     <= '0;
            r_dvs   <= '0;
            r_count <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else if (w_accept) begin
            r_pr    <= '0;
            r_q     <= dividend;
            r_dvs   <= divisor;
            r_count <= '0;
            if (w_zero) begin
                // Divide-by-zero completes at the accepting edge itself.
                r_quot <= '1;
                r_rem  <= dividend;
                r_dbz  <= 1'b1;
            end
        end else if (r_state == S_RUN) begin
            r_pr    <= w_pr_nxt;
            r_q     <= w_q_nxt;
            r_count <= w_last ? '0 : r_count + 1'b1;
            if (w_last) begin
                r_quot <= w_q_nxt;
                r_rem  <= w_pr_nxt[WIDTH-1:0];
                r_dbz  <= 1'b0;
            end
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_FIN);

endmodule

// File: doc/seq_divider8.md
Name: seq_divider8

Overview:
- Iterative radix-2 restoring unsigned divider. It is the inverse-operation companion to the team's combinational 8x8 Wallace multiplier.
- Takes a WIDTH-bit dividend and a WIDTH-bit divisor and produces a quotient and a remainder.
- Produces one quotient bit per clock, MSB first, under a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic unit. Its results are checked against the identity dividend = quotient*divisor + remainder.

Parameters:
- WIDTH, 8, operand, quotient and remainder width (valid range 2..32).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; accepted only when busy=0.
- dividend  input  WIDTH  numerator; sampled at the accepting edge only.
- divisor  input  WIDTH  denominator; sampled at the accepting edge only.
- quotient  output  WIDTH  registered result.
- remainder  output  WIDTH  registered result.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- div_by_zero  output  1  status of the last completed operation.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State returns to IDLE.
  - quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
  - Iteration counter and working registers are cleared.
  - The in-flight operation is discarded; no done pulse follows.
- States: IDLE, RUN, FIN.
- IDLE:
  - On an edge with start=1, capture the operands into working registers.
  - divisor!=0: partial remainder PR(WIDTH+1 bits)=0, shift register Q=dividend, count=0, go to RUN. busy=1 from that edge.
  - divisor==0: go to FIN directly. Load quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1. done=1 in the very next cycle. busy stays 0.
- RUN: each edge performs one iteration.
  - {PR,Q} shifts left one bit; T = PR - {1'b0,divisor}.
  - If T is non-negative (MSB=0): PR=T, Q[0]=1. Otherwise PR is unchanged and Q[0]=0.
  - count increments.
  - On the edge where count reaches WIDTH-1 (the WIDTH-th iteration): load quotient=Q_final, remainder=PR_final[WIDTH-1:0], div_by_zero=0, busy=0, done=1; go to FIN.
- FIN: lasts exactly one cycle with done=1, then done returns to 0.
  - start=1 on the FIN edge is accepted exactly as in IDLE, giving back-to-back operation with no bubble.
  - Otherwise the state returns to IDLE.
- Latency:
  - Normal operation: done=1 in the cycle beginning WIDTH edges after the accepting edge (8 for the default).
  - Divide-by-zero: 1 edge.
- Output hold:
  - quotient, remainder and div_by_zero change only at a completion edge.
  - They hold their values through IDLE and through a following RUN, until the next completion.
- start while busy=1 is ignored: no effect on the state, the counter or the captured operands.
- Operand inputs may change freely after the accepting edge.
- Arithmetic: unsigned only. The PR register is WIDTH+1 bits so the subtract's sign bit is never lost.
- Invariant: at completion with divisor!=0, remainder < divisor.

Test Plan:
- dividend=200, divisor=7, start pulsed one cycle: busy=1 for 8 cycles, then done=1 for 1 cycle with quotient=28, remainder=4, div_by_zero=0.
- 255/1 -> quotient=255, remainder=0. 5/9 -> quotient=0, remainder=5. 255/255 -> quotient=1, remainder=0. All complete with 8-cycle latency.
- 0/0, then 37/0: each gives done one edge after acceptance, quotient=255, div_by_zero=1. Remainders are 0 and 37 respectively; busy never rises.
- Back-to-back:
  - Start 100/3; during its done cycle, present start with 9/2.
  - First result 33/1 is seen; done pulses again exactly 8 edges later with 4/1.
  - A start pulse issued mid-operation (cycle 3) is ignored and the first result is unaffected.
- Reset mid-operation: assert rst asynchronously 4 cycles into 200/7. All outputs read 0 immediately and no done pulse follows. After release, 50/6 yields 8/2 with normal latency.
- Exhaustive sweep, all 65536 operand pairs with a random idle gap of 0-3 cycles between operations:
  - Every result matches the reference model q=a/b, r=a%b.
  - Zero divisors follow the div_by_zero rule.
  - The identity dividend = quotient*divisor + remainder holds for every nonzero-divisor result.
